// File: rtl/veririsc_pkg.sv
// Shared encodings for the VeriRISC CPU control path.
// Opcode values, phase numbering and the ALU-opcode class.
package veririsc_pkg;

  localparam int OP_W    = 3;
  localparam int PHASE_W = 3;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  function automatic logic is_aluop(logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// VeriRISC phase sequencer: 8-phase instruction cycle,
// per-phase strobes for PC, memory, IR and accumulator.
module cpu_sequencer
  import veririsc_pkg::*;
#(
  parameter int OP_W    = 3,
  parameter int PHASE_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            sel,
  output logic            rd,
  output logic            ld_ir,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            halt,
  output logic            data_e,
  output logic            ld_ac,
  output logic            wr
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_nxt;
  logic               halted;
  logic               halted_nxt;
  logic               aluop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= '0;
      halted <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      halted <= halted_nxt;
    end
  end

  // Phase freezes at OP_ADDR once HLT is taken
  always_comb begin
    phase_nxt  = phase;
    halted_nxt = halted;
    if (!halted) begin
      if (phase == PH_OP_ADDR && opcode == OP_HLT)
        halted_nxt = 1'b1;
      else
        phase_nxt = phase + PHASE_W'(1);
    end
  end

  assign aluop = is_aluop(opcode);

  // Phases 0..3 never look at opcode/zero
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: begin
          rd = aluop;
        end
        PH_ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed instructions plus
// random opcodes against a per-phase output model.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc;
  logic       halt, data_e, ld_ac, wr;

  int errors = 0;
  int checks = 0;

  int m_ph;
  bit m_halted;

  cpu_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .halt   (halt),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs_now();
    return {sel, rd, ld_ir, inc_pc, ld_pc,
            halt, data_e, ld_ac, wr};
  endfunction

  // Order: sel rd ld_ir inc_pc ld_pc halt data_e ld_ac wr
  function automatic logic [8:0] model(int ph, logic [2:0] op,
                                       logic z, bit hlt);
    bit alu, e_sel, e_rd, e_ir, e_inc, e_ldpc;
    bit e_halt, e_de, e_ac, e_wr;
    if (hlt) return 9'b000001000;
    alu    = (op >= 3'd2) && (op <= 3'd5);
    e_sel  = (ph <= 3);
    e_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    e_ir   = (ph == 2) || (ph == 3);
    e_inc  = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    e_ldpc = (ph >= 6) && (op == 3'd7);
    e_halt = (ph == 4) && (op == 3'd0);
    e_de   = (ph >= 6) && (op == 3'd6);
    e_ac   = (ph == 7) && alu;
    e_wr   = (ph == 7) && (op == 3'd6);
    return {e_sel, e_rd, e_ir, e_inc, e_ldpc,
            e_halt, e_de, e_ac, e_wr};
  endfunction

  task automatic chk(string tag, logic [8:0] exp);
    logic [8:0] obs;
    obs = outs_now();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s ph=%0d obs=%b exp=%b", tag, m_ph, obs, exp);
    end
    checks++;
    assert (!(inc_pc && ld_pc)) else begin
      errors++;
      $error("FAIL %s inc_ld_both obs=1 exp=0", tag);
    end
  endtask

  task automatic adv_model();
    if (!m_halted) begin
      if (m_ph == 4 && opcode == 3'd0) m_halted = 1'b1;
      else m_ph = (m_ph + 1) % 8;
    end
  endtask

  // Inputs are set just after posedge; outputs checked at negedge
  task automatic step(string tag, logic [2:0] op, logic z);
    if (m_ph < 3 && !m_halted) begin
      opcode = 3'($urandom);
      zero   = 1'($urandom);
    end else begin
      opcode = op;
      zero   = z;
    end
    @(negedge clk);
    chk(tag, model(m_ph, opcode, zero, m_halted));
    @(posedge clk);
    adv_model();
    #1;
  endtask

  task automatic run_instr(string tag, logic [2:0] op, logic z);
    for (int i = 0; i < 8; i++) step(tag, op, z);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b0;
    #1;
    m_ph = 0;
    m_halted = 1'b0;
    chk(tag, 9'b100000000);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, 9'b100000000);
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    m_ph   = 0;
    m_halted = 1'b0;
    #2;
    do_reset("reset");

    run_instr("add", 3'd2, 1'b0);
    run_instr("skz_z1", 3'd1, 1'b1);
    run_instr("skz_z0", 3'd1, 1'b0);
    run_instr("jmp", 3'd7, 1'b1);
    run_instr("sto", 3'd6, 1'b0);
    run_instr("and", 3'd3, 1'b1);
    run_instr("xor", 3'd4, 1'b0);
    run_instr("lda", 3'd5, 1'b1);

    for (int n = 0; n < 40; n++)
      run_instr("rand", 3'($urandom_range(7, 1)), 1'($urandom));

    // Async reset in the middle of STO phase 7
    for (int i = 0; i < 7; i++) step("sto_pre", 3'd6, 1'b0);
    opcode = 3'd6;
    @(negedge clk);
    chk("sto_ph7", model(m_ph, opcode, zero, m_halted));
    #2;
    do_reset("sto_abort");
    run_instr("after_abort", 3'd2, 1'b0);

    run_instr("hlt", 3'd0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("halted", 3'($urandom), 1'($urandom));
    do_reset("hlt_exit");
    run_instr("post_hlt", 3'd7, 1'b0);
    run_instr("post_hlt2", 3'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
